// File: rtl/ahb_rr_arbiter.sv
// Round-robin, burst-aware AHB bus arbiter with HLOCK support and bounded INCR tenure.
// Latency: grant moves on the accept edge that ends a tenure; ownership follows one accept edge later.
// Backpressure: hready low freezes every register; updates happen only on accept edges.
module ahb_rr_arbiter #(
  parameter int M_NUM          = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [M_NUM-1:0] hbusreq,
  input  logic [M_NUM-1:0] hlock,
  input  logic [1:0]       htrans,
  input  logic [2:0]       hburst,
  input  logic             hready,
  input  logic             hresp,
  output logic [M_NUM-1:0] hgrant,
  output logic [3:0]       hmaster,
  output logic [3:0]       hmaster_d,
  output logic             hmastlock
);

  localparam int HCW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;

  localparam logic [M_NUM-1:0] GNT_RST  = M_NUM'(1) << DEFAULT_MASTER;
  localparam logic [3:0]       MST_RST  = 4'(DEFAULT_MASTER);
  localparam logic [HCW-1:0]   HOLD_MAX = HCW'(MAX_HOLD);

  // Registered state
  logic [M_NUM-1:0] gnt_q, gnt_d;
  logic [3:0]       own_q, own_d;          // address-phase owner
  logic [3:0]       dph_own_q, dph_own_d;  // data-phase owner
  logic             mlock_q, mlock_d;
  logic [3:0]       rem_q, rem_d;          // beats left in a fixed burst, minus one
  logic [HCW-1:0]   hcnt_q, hcnt_d;        // beats accepted in the current tenure

  // Request/lock/grant widened to 16 so a 4-bit index always selects cleanly
  logic [15:0] req_ext;
  logic [15:0] lock_ext;
  logic [15:0] gnt_ext;

  assign req_ext  = 16'(hbusreq);
  assign lock_ext = 16'(hlock);
  assign gnt_ext  = 16'(gnt_q);

  // Burst length minus one; INCR is open-ended and never tracked by rem
  function automatic logic [3:0] len_m1(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: len_m1 = 4'd3;
      3'd4, 3'd5: len_m1 = 4'd7;
      3'd6, 3'd7: len_m1 = 4'd15;
      default:    len_m1 = 4'd0;
    endcase
  endfunction

  // Encode the current one-hot grant into an index (target of the next handover)
  logic [3:0] gnt_idx;
  always_comb begin
    gnt_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (gnt_ext[i[3:0]]) gnt_idx = i[3:0];
    end
  end

  // Beat and tenure counters follow the owner's HTRANS on accept edges
  always_comb begin
    rem_d  = rem_q;
    hcnt_d = hcnt_q;
    if (hready) begin
      case (htrans)
        TR_NONSEQ: begin
          rem_d  = len_m1(hburst);
          hcnt_d = HCW'(1);
        end
        TR_SEQ: begin
          rem_d  = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
          hcnt_d = (hcnt_q < HOLD_MAX) ? hcnt_q + HCW'(1) : HOLD_MAX;
        end
        TR_IDLE: begin
          rem_d  = 4'd0;
          hcnt_d = '0;
        end
        TR_BUSY: begin
          rem_d  = rem_q;
          hcnt_d = hcnt_q;
        end
        default: begin
          rem_d  = rem_q;
          hcnt_d = hcnt_q;
        end
      endcase
    end
  end

  // Tenure end: idle, error, last beat of a burst, or an INCR owner that let go or hit its cap
  logic own_req, locked, fixed_burst, rel;
  assign own_req     = req_ext[own_q];
  assign locked      = lock_ext[own_q] & own_req;
  assign fixed_burst = (hburst != HB_SINGLE) && (hburst != HB_INCR);
  assign rel = !locked && (
                 (htrans == TR_IDLE) ||
                 hresp ||
                 ((htrans == TR_NONSEQ) && (hburst == HB_SINGLE)) ||
                 ((htrans == TR_SEQ) && fixed_burst && (rem_q == 4'd1)) ||
                 ((hburst == HB_INCR) && !own_req) ||
                 ((hburst == HB_INCR) && (htrans == TR_SEQ) && (hcnt_d == HOLD_MAX)));

  // Circular search starting just after the owner, so the owner ranks last
  logic [4:0] cand;
  logic [3:0] pick;
  logic       found;
  always_comb begin
    cand  = 5'd0;
    pick  = MST_RST;
    found = 1'b0;
    for (int i = 1; i <= M_NUM; i++) begin
      cand = {1'b0, own_q} + 5'(i);
      if (cand >= 5'(M_NUM)) cand = cand - 5'(M_NUM);
      if (!found && req_ext[cand[3:0]]) begin
        found = 1'b1;
        pick  = cand[3:0];
      end
    end
  end

  logic [M_NUM-1:0] sel_onehot;
  assign sel_onehot = M_NUM'(1) << pick;

  // Grant, ownership handover, data-phase owner and lock indication
  always_comb begin
    gnt_d     = gnt_q;
    own_d     = own_q;
    dph_own_d = dph_own_q;
    mlock_d   = mlock_q;
    if (hready) begin
      own_d     = gnt_idx;
      dph_own_d = own_q;
      mlock_d   = lock_ext[gnt_idx];
      if (rel) gnt_d = found ? sel_onehot : GNT_RST;
    end
  end

  // State registers; reset abandons any in-flight burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_q     <= GNT_RST;
      own_q     <= MST_RST;
      dph_own_q <= MST_RST;
      mlock_q   <= 1'b0;
      rem_q     <= 4'd0;
      hcnt_q    <= '0;
    end else begin
      gnt_q     <= gnt_d;
      own_q     <= own_d;
      dph_own_q <= dph_own_d;
      mlock_q   <= mlock_d;
      rem_q     <= rem_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign hgrant    = gnt_q;
  assign hmaster   = own_q;
  assign hmaster_d = dph_own_q;
  assign hmastlock = mlock_q;

endmodule
